sgnmpy_rnd: RTL and testbench

Pipelined signed multiplier with a built-in unsigned multiply core, convergent rounding or truncation of the product to a parametrised output width, and saturation with flag. It replaces the fixed-width sign-magnitude multiplier wrappers used in the modulator datapath. The sign-to-magnitude split, the product stages, the re-signing and the rounding all sit inside one `i_ce`-gated pipeline, with an auxiliary bit carried alongside.

---
 rtl/sgnmpy_rnd_if.sv | 30 +++
 rtl/sgnmpy_rnd.sv | 137 +++++++++++++
 tb/tb_sgnmpy_rnd.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sgnmpy_rnd_if.sv
// Operand/result bundle for the signed rounding multiplier.
// The driver side (master) issues operands, mode and sideband each enabled
// cycle; the multiplier side (slave) returns the rounded, saturated product
// with the sideband bit delayed to line up with it.
interface sgnmpy_rnd_if #(
   parameter int NA   = 14,
   parameter int NB   = 16,
   parameter int NOUT = 16
);

   logic                   i_ce;
   logic signed [NA-1:0]   i_a;
   logic signed [NB-1:0]   i_b;
   logic                   i_rnd;
   logic                   i_aux;
   logic signed [NOUT-1:0] o_p;
   logic                   o_sat;
   logic                   o_aux;

   modport master (
      output i_ce, i_a, i_b, i_rnd, i_aux,
      input  o_p, o_sat, o_aux
   );

   modport slave (
      input  i_ce, i_a, i_b, i_rnd, i_aux,
      output o_p, o_sat, o_aux
   );

endinterface

// File: rtl/sgnmpy_rnd.sv
// Pipelined signed multiplier: sign/magnitude split, unsigned product over
// MPYDLY stages, re-sign, then convergent rounding or floor truncation down
// to NOUT bits with positive saturation. Every register advances on i_ce and
// clears on a synchronous active-low reset. Latency is MPYDLY+3 enabled edges.
module sgnmpy_rnd #(
   parameter int NA     = 14,
   parameter int NB     = 16,
   parameter int NOUT   = 16,
   parameter int MPYDLY = 3
) (
   input logic         i_clk,
   input logic         i_reset_n,
   sgnmpy_rnd_if.slave bus
);

   localparam int NP = NA + NB;
   localparam int D  = NA + NB - 1 - NOUT;
   localparam int W1 = NP + 1;

   localparam logic signed [W1-1:0] MAX_P   = W1'((64'sd1 <<< (NOUT - 1)) - 64'sd1);
   localparam logic [NOUT-1:0]      MAX_OUT = {1'b0, {(NOUT - 1){1'b1}}};

   // magnitudes of the incoming operands; the most negative value maps to 2^(N-1)
   logic [NA-1:0] abs_a;
   logic [NB-1:0] abs_b;

   assign abs_a = bus.i_a[NA-1] ? ({NA{1'b0}} - bus.i_a) : bus.i_a;
   assign abs_b = bus.i_b[NB-1] ? ({NB{1'b0}} - bus.i_b) : bus.i_b;

   // stage 1 registers
   logic [NA-1:0] mag_a_r;
   logic [NB-1:0] mag_b_r;
   logic          sign_s1;
   logic          rnd_s1;
   logic          aux_s1;

   // product stages with matching sideband delay lines
   logic [NP-1:0] prod_pipe [MPYDLY];
   logic          sign_pipe [MPYDLY];
   logic          rnd_pipe  [MPYDLY];
   logic          aux_pipe  [MPYDLY];

   // re-signed product stage
   logic signed [NP-1:0] p_r;
   logic                 rnd_r;
   logic                 aux_r;

   // output stage
   logic signed [NOUT-1:0] p_out_r;
   logic                   sat_out_r;
   logic                   aux_out_r;

   // rounding datapath, one bit wider than the product so the tie carry cannot wrap
   logic signed [W1-1:0] p_ext;
   logic signed [W1-1:0] bias;
   logic signed [W1-1:0] rnd_sum;
   logic signed [W1-1:0] r_full;

   assign p_ext = {p_r[NP-1], p_r};

   // half-even bias: 2^(D-1)-1 plus the bit that becomes the result LSB, nothing when D is zero
   generate
      if (D > 0) begin : g_round
         localparam logic [W1-1:0] HALF_M1 = W1'((64'd1 << (D - 1)) - 64'd1);
         assign bias = rnd_r ? (HALF_M1 + {{(W1 - 1){1'b0}}, p_r[D]}) : '0;
      end else begin : g_noround
         assign bias = '0;
      end
   endgenerate

   // add the rounding bias and drop the D low bits with an arithmetic shift
   always_comb begin
      rnd_sum = '0;
      r_full  = '0;
      rnd_sum = p_ext + bias;
      r_full  = rnd_sum >>> D;
   end

   // whole pipeline: reset clears every stage, otherwise advance only on clock enable
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         mag_a_r   <= '0;
         mag_b_r   <= '0;
         sign_s1   <= 1'b0;
         rnd_s1    <= 1'b0;
         aux_s1    <= 1'b0;
         for (int k = 0; k < MPYDLY; k++) begin
            prod_pipe[k] <= '0;
            sign_pipe[k] <= 1'b0;
            rnd_pipe[k]  <= 1'b0;
            aux_pipe[k]  <= 1'b0;
         end
         p_r       <= '0;
         rnd_r     <= 1'b0;
         aux_r     <= 1'b0;
         p_out_r   <= '0;
         sat_out_r <= 1'b0;
         aux_out_r <= 1'b0;
      end else if (bus.i_ce) begin
         mag_a_r <= abs_a;
         mag_b_r <= abs_b;
         sign_s1 <= bus.i_a[NA-1] ^ bus.i_b[NB-1];
         rnd_s1  <= bus.i_rnd;
         aux_s1  <= bus.i_aux;

         prod_pipe[0] <= {{NB{1'b0}}, mag_a_r} * {{NA{1'b0}}, mag_b_r};
         sign_pipe[0] <= sign_s1;
         rnd_pipe[0]  <= rnd_s1;
         aux_pipe[0]  <= aux_s1;
         for (int k = 1; k < MPYDLY; k++) begin
            prod_pipe[k] <= prod_pipe[k-1];
            sign_pipe[k] <= sign_pipe[k-1];
            rnd_pipe[k]  <= rnd_pipe[k-1];
            aux_pipe[k]  <= aux_pipe[k-1];
         end

         p_r   <= sign_pipe[MPYDLY-1] ? ({NP{1'b0}} - prod_pipe[MPYDLY-1])
                                      : prod_pipe[MPYDLY-1];
         rnd_r <= rnd_pipe[MPYDLY-1];
         aux_r <= aux_pipe[MPYDLY-1];

         if (r_full > MAX_P) begin
            p_out_r   <= MAX_OUT;
            sat_out_r <= 1'b1;
         end else begin
            p_out_r   <= r_full[NOUT-1:0];
            sat_out_r <= 1'b0;
         end
         aux_out_r <= aux_r;
      end
   end

   assign bus.o_p   = p_out_r;
   assign bus.o_sat = sat_out_r;
   assign bus.o_aux = aux_out_r;

endmodule

// File: tb/tb_sgnmpy_rnd.sv
// Self-checking bench for sgnmpy_rnd. Expected results come from an
// arithmetic reference (exact product, floor division, half-even tie rule,
// clamp) fed through a queue that models the enabled-edge latency.
module tb_sgnmpy_rnd;

   localparam int    NA     = 14;
   localparam int    NB     = 16;
   localparam int    NOUT   = 16;
   localparam int    MPYDLY = 3;
   localparam int    L      = MPYDLY + 3;
   localparam int    D      = NA + NB - 1 - NOUT;
   localparam longint SCALE = longint'(1) << D;
   localparam longint MAXV  = (longint'(1) << (NOUT - 1)) - 1;

   typedef struct packed {
      logic signed [NOUT-1:0] p;
      logic                   sat;
      logic                   aux;
   } exp_t;

   logic i_clk;
   logic i_reset_n;

   sgnmpy_rnd_if #(.NA(NA), .NB(NB), .NOUT(NOUT)) bus ();

   sgnmpy_rnd #(.NA(NA), .NB(NB), .NOUT(NOUT), .MPYDLY(MPYDLY)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   int   errors = 0;
   int   checks = 0;
   exp_t q_exp[$];
   exp_t cur_exp = '0;

   // free-running clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // exact product, floor to 2^-D resolution, optional half-even nudge, clamp
   function automatic exp_t ref_model(input longint a, input longint b, input logic rnd);
      longint prod, q, r;
      exp_t   e;
      prod = a * b;
      q    = prod / SCALE;
      r    = prod - q * SCALE;
      if (r < 0) begin
         q = q - 1;
         r = r + SCALE;
      end
      if (rnd && ((2 * r > SCALE) || ((2 * r == SCALE) && ((q % 2) != 0))))
         q = q + 1;
      e.aux = 1'b0;
      if (q > MAXV) begin
         e.p   = NOUT'(MAXV);
         e.sat = 1'b1;
      end else begin
         e.p   = NOUT'(q);
         e.sat = 1'b0;
      end
      return e;
   endfunction

   // drive one cycle of inputs, advance the reference across the edge, settle
   task automatic applyStimulus(input logic signed [NA-1:0] a, input logic signed [NB-1:0] b,
                                input logic rnd, input logic aux, input logic ce);
      exp_t e;
      bus.i_a   = a;
      bus.i_b   = b;
      bus.i_rnd = rnd;
      bus.i_aux = aux;
      bus.i_ce  = ce;
      @(posedge i_clk);
      if (!i_reset_n) begin
         q_exp.delete();
         cur_exp = '0;
      end else if (ce) begin
         e     = ref_model(a, b, rnd);
         e.aux = aux;
         q_exp.push_back(e);
         if (q_exp.size() >= L) cur_exp = q_exp.pop_front();
      end
      #1;
   endtask

   // issue one operand pair, then idle until it reaches the outputs
   task automatic runSingle(input logic signed [NA-1:0] a, input logic signed [NB-1:0] b,
                            input logic rnd, output logic signed [NOUT-1:0] p, output logic sat);
      applyStimulus(a, b, rnd, 1'b1, 1'b1);
      repeat (L - 1) applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
      p   = bus.o_p;
      sat = bus.o_sat;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(NA'($urandom), NB'($urandom), 1'b1, 1'b1, (i != 1));
         checks++;
         if (bus.o_p !== '0 || bus.o_sat !== 1'b0 || bus.o_aux !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_clear cyc%0d: got p=%0d sat=%b aux=%b, want p=0 sat=0 aux=0",
                     i, bus.o_p, bus.o_sat, bus.o_aux);
         end
      end
      i_reset_n = 1'b1;
   endtask

   task automatic test_latency();
      logic                   want_aux;
      logic signed [NOUT-1:0] want_p;
      applyStimulus(14'sd3, 16'sd2048, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus('0, '0, 1'b1, 1'b0, 1'b1);
         want_aux = (i == L - 1);
         want_p   = (i == L - 1) ? 16'sd1 : 16'sd0;
         checks++;
         if (bus.o_aux !== want_aux || bus.o_p !== want_p) begin
            errors++;
            $display("[TB] FAIL latency cyc%0d: got p=%0d aux=%b, want p=%0d aux=%b",
                     i, bus.o_p, bus.o_aux, want_p, want_aux);
         end
      end
   endtask

   task automatic test_round_ties();
      int   ta[8] = '{3, 5, 1, 3, -3, -3, -1, -1};
      logic tr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int   tw[8] = '{2, 2, 0, 1, -2, -2, 0, -1};
      logic signed [NOUT-1:0] p;
      logic sat;
      for (int i = 0; i < 8; i++) begin
         runSingle(NA'(ta[i]), 16'sd4096, tr[i], p, sat);
         checks++;
         if (p !== NOUT'(tw[i]) || sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL round a=%0d rnd=%b: got p=%0d sat=%b, want p=%0d sat=0",
                     ta[i], tr[i], p, sat, tw[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic signed [NOUT-1:0] p;
      logic sat;
      runSingle(-14'sd8192, -16'sd32768, 1'b1, p, sat);
      checks++;
      if (p !== 16'sd32767 || sat !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_pos: got p=%0d sat=%b, want p=32767 sat=1", p, sat);
      end
      runSingle(14'sd8191, -16'sd32768, 1'b1, p, sat);
      checks++;
      if (p !== -16'sd32764 || sat !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_neg_tie: got p=%0d sat=%b, want p=-32764 sat=0", p, sat);
      end
      runSingle(-14'sd8192, -16'sd32768, 1'b0, p, sat);
      checks++;
      if (p !== 16'sd32767 || sat !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_trunc: got p=%0d sat=%b, want p=32767 sat=1", p, sat);
      end
   endtask

   task automatic test_ce_gating();
      exp_t held;
      logic ce;
      held = '0;
      for (int i = 0; i < 13 + L; i++) begin
         ce = !(i >= 5 && i < 8);
         if (i < 13)
            applyStimulus(NA'($urandom), NB'($urandom), 1'($urandom), 1'($urandom), ce);
         else
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
         checks++;
         if ({bus.o_p, bus.o_sat, bus.o_aux} !== {cur_exp.p, cur_exp.sat, cur_exp.aux}) begin
            errors++;
            $display("[TB] FAIL ce_stream cyc%0d: got p=%0d sat=%b aux=%b, want p=%0d sat=%b aux=%b",
                     i, bus.o_p, bus.o_sat, bus.o_aux, cur_exp.p, cur_exp.sat, cur_exp.aux);
         end
         if (i == 4) held = cur_exp;
         if (!ce) begin
            checks++;
            if ({bus.o_p, bus.o_sat, bus.o_aux} !== {held.p, held.sat, held.aux}) begin
               errors++;
               $display("[TB] FAIL ce_freeze cyc%0d: got p=%0d sat=%b aux=%b, want p=%0d sat=%b aux=%b",
                        i, bus.o_p, bus.o_sat, bus.o_aux, held.p, held.sat, held.aux);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic signed [NA-1:0] a;
      logic signed [NB-1:0] b;
      for (int i = 0; i < 40 + L; i++) begin
         a = NA'($urandom);
         b = NB'($urandom);
         if ($urandom_range(0, 7) == 0) a = {1'b1, {(NA - 1){1'b0}}};
         if ($urandom_range(0, 7) == 0) b = {1'b1, {(NB - 1){1'b0}}};
         applyStimulus(a, b, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
         checks++;
         if ({bus.o_p, bus.o_sat, bus.o_aux} !== {cur_exp.p, cur_exp.sat, cur_exp.aux}) begin
            errors++;
            $display("[TB] FAIL b2b cyc%0d: got p=%0d sat=%b aux=%b, want p=%0d sat=%b aux=%b",
                     i, bus.o_p, bus.o_sat, bus.o_aux, cur_exp.p, cur_exp.sat, cur_exp.aux);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int aux_seen;
      aux_seen = 0;
      for (int i = 0; i < 4; i++)
         applyStimulus(NA'($urandom_range(100, 8000)), NB'($urandom_range(100, 30000)),
                       1'($urandom), 1'b1, 1'b1);
      i_reset_n = 1'b0;
      applyStimulus(NA'($urandom), NB'($urandom), 1'b1, 1'b1, 1'b1);
      i_reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i < 2)
            applyStimulus(NA'($urandom), NB'($urandom), 1'($urandom), 1'b1, 1'b1);
         else
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
         if (bus.o_aux === 1'b1) aux_seen++;
         checks++;
         if ({bus.o_p, bus.o_sat, bus.o_aux} !== {cur_exp.p, cur_exp.sat, cur_exp.aux}) begin
            errors++;
            $display("[TB] FAIL rst_mid cyc%0d: got p=%0d sat=%b aux=%b, want p=%0d sat=%b aux=%b",
                     i, bus.o_p, bus.o_sat, bus.o_aux, cur_exp.p, cur_exp.sat, cur_exp.aux);
         end
      end
      checks++;
      if (aux_seen != 2) begin
         errors++;
         $display("[TB] FAIL rst_mid_count: got aux pulses=%0d, want 2", aux_seen);
      end
   endtask

   // run every scenario in order, then report
   initial begin
      i_reset_n = 1'b0;
      bus.i_ce  = 1'b0;
      bus.i_a   = '0;
      bus.i_b   = '0;
      bus.i_rnd = 1'b0;
      bus.i_aux = 1'b0;
      test_reset();
      test_latency();
      test_round_ties();
      test_saturation();
      test_ce_gating();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
